// File: rtl/mc_bank_track_if.sv
// Request/lookup bus between the SDRAM command path and the open-row tracker.
interface mc_bank_track_if #(
  parameter int unsigned ROW_W = 13,
  parameter int unsigned TMO_W = 8
);
  logic [ROW_W-1:0] row_adr;
  logic [1:0]       bank_adr;
  logic             bank_set;
  logic             bank_clr;
  logic             bank_clr_all;
  logic             acc;
  logic [TMO_W-1:0] idle_tmo;
  logic             bank_open;
  logic             row_same;
  logic             any_open;
  logic             pc_all_req;

  modport master (
    output row_adr, bank_adr, bank_set, bank_clr, bank_clr_all, acc, idle_tmo,
    input  bank_open, row_same, any_open, pc_all_req
  );

  modport slave (
    input  row_adr, bank_adr, bank_set, bank_clr, bank_clr_all, acc, idle_tmo,
    output bank_open, row_same, any_open, pc_all_req
  );
endinterface

// File: rtl/mc_bank_track.sv
// Per-bank open-row tracker with hit/conflict lookup and idle precharge-all request.
module mc_bank_track #(
  parameter int unsigned ROW_W = 13,
  parameter int unsigned TMO_W = 8
) (
  input  logic             clk,
  input  logic             rst_,
  mc_bank_track_if.slave   bus
);

  localparam int unsigned NBANK = 4;

  typedef enum logic {IDLE, REQ} req_state_t;

  logic [NBANK-1:0] vld;
  logic [NBANK-1:0] vld_d;
  logic [ROW_W-1:0] orow [NBANK];
  logic [TMO_W-1:0] idle_cnt;
  logic [TMO_W-1:0] idle_cnt_d;
  req_state_t       state;
  req_state_t       state_d;
  logic             any_open_c;
  logic             tmo_hit_c;

  // Zero-latency lookup against the registered bank state
  assign any_open_c     = |vld;
  assign bus.any_open   = any_open_c;
  assign bus.bank_open  = vld[bus.bank_adr];
  assign bus.row_same   = vld[bus.bank_adr] & (orow[bus.bank_adr] == bus.row_adr);
  assign bus.pc_all_req = (state == REQ);

  // Later assignments take priority: clr_all, then clr, then set
  always_comb begin
    vld_d = vld;
    if (bus.bank_clr_all) vld_d = '0;
    if (bus.bank_clr)     vld_d[bus.bank_adr] = 1'b0;
    if (bus.bank_set)     vld_d[bus.bank_adr] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      vld <= '0;
      for (int i = 0; i < int'(NBANK); i++) orow[i] <= '0;
    end else begin
      vld <= vld_d;
      if (bus.bank_set) orow[bus.bank_adr] <= bus.row_adr;
    end
  end

  // Idle counter restarts on any activity or when nothing is open; saturates
  always_comb begin
    idle_cnt_d = idle_cnt;
    if (bus.acc || bus.bank_set || bus.bank_clr_all || !any_open_c)
      idle_cnt_d = '0;
    else if (idle_cnt != '1)
      idle_cnt_d = idle_cnt + TMO_W'(1);
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) idle_cnt <= '0;
    else       idle_cnt <= idle_cnt_d;
  end

  assign tmo_hit_c = (bus.idle_tmo != '0) && any_open_c &&
                     (idle_cnt == (bus.idle_tmo - TMO_W'(1))) &&
                     !bus.acc && !bus.bank_set && !bus.bank_clr_all;

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) state <= IDLE;
    else       state <= state_d;
  end

  // Request is held until the precharge-all lands or every bank closes
  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (tmo_hit_c) state_d = REQ;
      REQ:     if (bus.bank_clr_all || !any_open_c) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mc_bank_track.sv
// Scoreboard bench for mc_bank_track: directed stimulus queues expectations, monitor compares.
module tb_mc_bank_track;

  logic clk;
  logic rst_;

  mc_bank_track_if #(.ROW_W(13), .TMO_W(8)) bus ();

  mc_bank_track #(.ROW_W(13), .TMO_W(8)) dut (
    .clk  (clk),
    .rst_ (rst_),
    .bus  (bus)
  );

  typedef struct {
    string      name;
    logic [3:0] outs;   // {bank_open, row_same, any_open, pc_all_req}
    logic       chk_cnt;
    logic [7:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input logic set, input logic clr, input logic clr_all,
                      input logic a, input logic [1:0] bank, input logic [12:0] row);
    @(posedge clk);
    #1;
    bus.bank_set     = set;
    bus.bank_clr     = clr;
    bus.bank_clr_all = clr_all;
    bus.acc          = a;
    bus.bank_adr     = bank;
    bus.row_adr      = row;
  endtask

  task automatic exp_out(input string name, input logic bo, input logic rs,
                         input logic ao, input logic pr,
                         input logic chk, input logic [7:0] cnt);
    exp_t e;
    e.name    = name;
    e.outs    = {bo, rs, ao, pr};
    e.chk_cnt = chk;
    e.cnt     = cnt;
    exp_q.push_back(e);
  endtask

  // Monitor: outputs are sampled mid-cycle, away from the active edge
  always @(negedge clk) begin
    while (exp_q.size() > 0) begin
      exp_t e;
      logic [3:0] act;
      e   = exp_q.pop_front();
      act = {bus.bank_open, bus.row_same, bus.any_open, bus.pc_all_req};
      n_checks++;
      if (act === e.outs) n_pass++;
      else $display("FAIL %s: {open,same,any,req} got %b want %b", e.name, act, e.outs);
      if (e.chk_cnt) begin
        n_checks++;
        if (dut.idle_cnt === e.cnt) n_pass++;
        else $display("FAIL %s_cnt: idle_cnt got %0d want %0d", e.name, dut.idle_cnt, e.cnt);
      end
    end
  end

  initial begin
    rst_             = 1'b0;
    bus.bank_set     = 1'b0;
    bus.bank_clr     = 1'b0;
    bus.bank_clr_all = 1'b0;
    bus.acc          = 1'b0;
    bus.bank_adr     = 2'd0;
    bus.row_adr      = 13'd0;
    bus.idle_tmo     = 8'd0;

    step(0, 0, 0, 0, 2'd1, 13'h0AB); exp_out("reset", 0, 0, 0, 0, 1, 8'd0);
    rst_ = 1'b1;

    // Basic hit / miss / closed lookups
    step(1, 0, 0, 0, 2'd1, 13'h0AB); exp_out("pre_set", 0, 0, 0, 0, 0, 8'd0);
    step(0, 0, 0, 0, 2'd1, 13'h0AB); exp_out("hit", 1, 1, 1, 0, 0, 8'd0);
    step(0, 0, 0, 0, 2'd1, 13'h0AC); exp_out("row_miss", 1, 0, 1, 0, 0, 8'd0);
    step(0, 0, 0, 0, 2'd2, 13'h0AB); exp_out("closed", 0, 0, 1, 0, 0, 8'd0);

    // set beats clr_all on its own bank; other banks still cleared
    step(1, 0, 1, 0, 2'd3, 13'h1FFF); exp_out("pre_setall", 0, 0, 1, 0, 0, 8'd0);
    step(0, 0, 0, 0, 2'd3, 13'h1FFF); exp_out("set_wins", 1, 1, 1, 0, 0, 8'd0);
    step(0, 0, 0, 0, 2'd1, 13'h0AB);  exp_out("others_clr", 0, 0, 1, 0, 0, 8'd0);
    step(0, 1, 0, 0, 2'd3, 13'h1FFF); exp_out("pre_clr", 1, 1, 1, 0, 0, 8'd0);
    step(0, 0, 0, 0, 2'd3, 13'h1FFF); exp_out("clr_last", 0, 0, 0, 0, 0, 8'd0);
    step(1, 1, 0, 0, 2'd2, 13'h055);  exp_out("pre_setclr", 0, 0, 0, 0, 0, 8'd0);
    step(0, 0, 0, 0, 2'd2, 13'h055);  exp_out("set_over_clr", 1, 1, 1, 0, 0, 8'd0);
    step(0, 1, 0, 0, 2'd2, 13'h055);
    step(0, 0, 0, 0, 2'd2, 13'h055);  exp_out("empty", 0, 0, 0, 0, 0, 8'd0);

    // Idle timeout of 5: request in cycle 5, held across acc/set, dropped by clr_all
    bus.idle_tmo = 8'd5;
    step(1, 0, 0, 0, 2'd0, 13'h010); exp_out("tmo_set", 0, 0, 0, 0, 0, 8'd0);
    for (int i = 0; i < 5; i++) begin
      step(0, 0, 0, 0, 2'd0, 13'h010); exp_out("tmo_wait", 1, 1, 1, 0, 0, 8'd0);
    end
    step(0, 0, 0, 0, 2'd0, 13'h010); exp_out("tmo_req", 1, 1, 1, 1, 0, 8'd0);
    step(0, 0, 0, 1, 2'd0, 13'h010); exp_out("req_acc", 1, 1, 1, 1, 0, 8'd0);
    step(1, 0, 0, 0, 2'd0, 13'h010); exp_out("req_set", 1, 1, 1, 1, 0, 8'd0);
    step(0, 0, 0, 0, 2'd0, 13'h010); exp_out("req_hold", 1, 1, 1, 1, 0, 8'd0);
    step(0, 0, 1, 0, 2'd0, 13'h010); exp_out("req_clrall", 1, 1, 1, 1, 0, 8'd0);
    step(0, 0, 0, 0, 2'd0, 13'h010); exp_out("req_drop", 0, 0, 0, 0, 0, 8'd0);

    // acc at the would-be firing cycle restarts the count; bank_clr closing all drops req
    step(1, 0, 0, 0, 2'd0, 13'h010); exp_out("tmo2_set", 0, 0, 0, 0, 0, 8'd0);
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 0, 0, 2'd0, 13'h010); exp_out("tmo2_wait", 1, 1, 1, 0, 0, 8'd0);
    end
    step(0, 0, 0, 1, 2'd0, 13'h010); exp_out("acc_block", 1, 1, 1, 0, 0, 8'd4);
    for (int i = 0; i < 5; i++) begin
      step(0, 0, 0, 0, 2'd0, 13'h010); exp_out("tmo2_rewait", 1, 1, 1, 0, 0, 8'd0);
    end
    step(0, 1, 0, 0, 2'd0, 13'h010); exp_out("tmo2_req", 1, 1, 1, 1, 0, 8'd0);
    step(0, 0, 0, 0, 2'd0, 13'h010); exp_out("req_noopen", 0, 0, 0, 1, 0, 8'd0);
    step(0, 0, 0, 0, 2'd0, 13'h010); exp_out("req_closed", 0, 0, 0, 0, 0, 8'd0);

    // Timeout disabled: no request, counter saturates
    bus.idle_tmo = 8'd0;
    step(1, 0, 0, 0, 2'd1, 13'h0AB); exp_out("dis_set", 0, 0, 0, 0, 0, 8'd0);
    for (int i = 0; i < 300; i++) begin
      step(0, 0, 0, 0, 2'd1, 13'h0AB);
      if (i == 254)      exp_out("dis_254", 1, 1, 1, 0, 1, 8'd254);
      else if (i == 299) exp_out("dis_sat", 1, 1, 1, 0, 1, 8'd255);
      else               exp_out("dis_idle", 1, 1, 1, 0, 0, 8'd0);
    end

    // All banks open with request pending, then asynchronous reset mid-cycle
    bus.idle_tmo = 8'd3;
    step(1, 0, 0, 0, 2'd0, 13'h001); exp_out("fill0", 0, 0, 1, 0, 0, 8'd0);
    step(1, 0, 0, 0, 2'd2, 13'h002); exp_out("fill2", 0, 0, 1, 0, 0, 8'd0);
    step(1, 0, 0, 0, 2'd3, 13'h003); exp_out("fill3", 0, 0, 1, 0, 0, 8'd0);
    step(1, 0, 0, 0, 2'd1, 13'h004); exp_out("fill1", 1, 0, 1, 0, 0, 8'd0);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 0, 2'd3, 13'h003); exp_out("full_wait", 1, 1, 1, 0, 0, 8'd0);
    end
    step(0, 0, 0, 0, 2'd3, 13'h003); exp_out("full_req", 1, 1, 1, 1, 0, 8'd0);
    step(0, 0, 0, 0, 2'd3, 13'h003);
    rst_ = 1'b0;
    exp_out("async_rst", 0, 0, 0, 0, 1, 8'd0);
    step(0, 0, 0, 0, 2'd1, 13'h004);
    rst_ = 1'b1;
    step(0, 0, 0, 0, 2'd1, 13'h004); exp_out("post_rst", 0, 0, 0, 0, 1, 8'd0);

    @(negedge clk);
    #1;
    n_checks++;
    if (exp_q.size() == 0) n_pass++;
    else $display("FAIL drain: queue depth got %0d want 0", exp_q.size());

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
